// File: rtl/cache_wb_line_ctrl.sv
// Direct-mapped write-back / write-allocate cache controller with multi-word lines,
// byte-masked writes, a whole-cache flush command and saturating hit/miss counters.
module cache_wb_line_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_rd_en,
  input  logic                    i_wr_en,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [DATA_WIDTH/8-1:0] i_mask,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_busy,
  input  logic                    i_flush,
  output logic                    o_flush_done,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic                    i_mem_ack,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic [31:0]             o_hit_cnt,
  output logic [31:0]             o_miss_cnt
);

  localparam int MASK_W  = DATA_WIDTH / 8;
  localparam int OFF_W   = $clog2(MASK_W);
  localparam int WORD_W  = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_W   = ADDR_WIDTH - OFF_W - WORD_W - IDX_W;
  localparam int WW      = (WORD_W > 0) ? WORD_W : 1;
  localparam int IW      = (IDX_W > 0) ? IDX_W : 1;
  localparam int RA_BITS = $clog2(LINES * LINE_WORDS);
  localparam int RA_W    = (RA_BITS > 0) ? RA_BITS : 1;
  localparam int NLINE   = 1 << IW;
  localparam int NWORD   = 1 << RA_W;
  localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);
  localparam logic [IW-1:0] LAST_LINE = IW'(LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_FL_SCAN,
    S_FL_WB
  } state_t;

  logic [DATA_WIDTH-1:0] data_ram [NWORD];
  logic [TAG_W-1:0]      tag_ram  [NLINE];
  logic [NLINE-1:0]      valid;
  logic [NLINE-1:0]      dirty;

  state_t                state, state_n;
  logic [WW-1:0]         word_cnt, word_cnt_n;
  logic [IW-1:0]         line_cnt, line_cnt_n;
  logic                  mem_req_n, mem_we_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic [DATA_WIDTH-1:0] mem_wdata_n;
  logic                  flush_done_n;
  logic                  miss_pending, miss_pending_n;
  logic [DATA_WIDTH-1:0] data_q;

  logic [TAG_W-1:0]      req_tag;
  logic [IW-1:0]         req_idx;
  logic [WW-1:0]         req_word;
  logic [IW-1:0]         line_idx;
  logic [WW-1:0]         word_nxt;
  logic                  req_any;
  logic                  hit;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] req_word_data;
  logic [DATA_WIDTH-1:0] merged;

  logic                  ram_we;
  logic [RA_W-1:0]       ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  tag_we;
  logic                  set_valid;
  logic                  set_dirty;
  logic                  clr_dirty;
  logic                  count_hit;
  logic                  count_miss;

  function automatic logic [ADDR_WIDTH-1:0] make_addr(input logic [TAG_W-1:0] t,
                                                      input logic [IW-1:0]    ix,
                                                      input logic [WW-1:0]    w);
    logic [ADDR_WIDTH-1:0] a;
    a = ADDR_WIDTH'(t) << (OFF_W + WORD_W + IDX_W);
    if (IDX_W > 0) a = a | (ADDR_WIDTH'(ix) << (OFF_W + WORD_W));
    if (WORD_W > 0) a = a | (ADDR_WIDTH'(w) << OFF_W);
    return a;
  endfunction

  function automatic logic [RA_W-1:0] ram_ix(input logic [IW-1:0] ix, input logic [WW-1:0] w);
    return RA_W'(int'(ix) * LINE_WORDS + int'(w));
  endfunction

  assign req_word = WW'((i_addr >> OFF_W) & ADDR_WIDTH'(LINE_WORDS - 1));
  assign req_idx  = IW'((i_addr >> (OFF_W + WORD_W)) & ADDR_WIDTH'(LINES - 1));
  assign req_tag  = TAG_W'(i_addr >> (OFF_W + WORD_W + IDX_W));
  assign req_any  = i_rd_en | i_wr_en;
  assign hit      = valid[req_idx] && (tag_ram[req_idx] == req_tag);
  assign word_nxt = word_cnt + WW'(1);

  // Flush states walk the cache with line_cnt; everything else works on the requested line.
  assign line_idx = (state == S_FL_SCAN || state == S_FL_WB) ? line_cnt : req_idx;

  assign req_word_data = data_ram[ram_ix(req_idx, req_word)];
  assign rd_hit        = !rst && (state == S_IDLE) && i_rd_en && hit;
  assign o_data        = rd_hit ? req_word_data : data_q;
  assign o_busy        = !rst && ((state != S_IDLE) || (req_any && !hit));

  always_comb begin
    merged = req_word_data;
    for (int b = 0; b < MASK_W; b++) begin
      if (i_mask[b]) merged[8*b +: 8] = i_data[8*b +: 8];
    end
  end

  always_comb begin
    state_n        = state;
    word_cnt_n     = word_cnt;
    line_cnt_n     = line_cnt;
    mem_req_n      = o_mem_req;
    mem_we_n       = o_mem_we;
    mem_addr_n     = o_mem_addr;
    mem_wdata_n    = o_mem_wdata;
    flush_done_n   = 1'b0;
    miss_pending_n = miss_pending;
    ram_we         = 1'b0;
    ram_waddr      = ram_ix(req_idx, req_word);
    ram_wdata      = merged;
    tag_we         = 1'b0;
    set_valid      = 1'b0;
    set_dirty      = 1'b0;
    clr_dirty      = 1'b0;
    count_hit      = 1'b0;
    count_miss     = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_any) begin
          if (hit) begin
            if (miss_pending) miss_pending_n = 1'b0;
            else              count_hit      = 1'b1;
            if (!i_rd_en) begin
              ram_we    = 1'b1;
              set_dirty = 1'b1;
            end
          end else begin
            count_miss     = 1'b1;
            miss_pending_n = 1'b1;
            word_cnt_n     = '0;
            mem_req_n      = 1'b1;
            if (valid[req_idx] && dirty[req_idx]) begin
              state_n     = S_WB;
              mem_we_n    = 1'b1;
              mem_addr_n  = make_addr(tag_ram[line_idx], line_idx, '0);
              mem_wdata_n = data_ram[ram_ix(line_idx, '0)];
            end else begin
              state_n     = S_FILL;
              mem_we_n    = 1'b0;
              mem_addr_n  = make_addr(req_tag, req_idx, '0);
              mem_wdata_n = '0;
            end
          end
        end else if (i_flush) begin
          state_n    = S_FL_SCAN;
          line_cnt_n = '0;
        end
      end

      S_WB, S_FL_WB: begin
        if (o_mem_req && i_mem_ack) begin
          if (word_cnt == LAST_WORD) begin
            clr_dirty  = 1'b1;
            word_cnt_n = '0;
            mem_we_n   = 1'b0;
            if (state == S_WB) begin
              state_n    = S_FILL;
              mem_req_n  = 1'b1;
              mem_addr_n = make_addr(req_tag, req_idx, '0);
            end else if (line_cnt == LAST_LINE) begin
              state_n      = S_IDLE;
              mem_req_n    = 1'b0;
              flush_done_n = 1'b1;
            end else begin
              state_n    = S_FL_SCAN;
              mem_req_n  = 1'b0;
              line_cnt_n = line_cnt + IW'(1);
            end
          end else begin
            word_cnt_n  = word_nxt;
            mem_addr_n  = make_addr(tag_ram[line_idx], line_idx, word_nxt);
            mem_wdata_n = data_ram[ram_ix(line_idx, word_nxt)];
          end
        end
      end

      S_FILL: begin
        if (o_mem_req && i_mem_ack) begin
          ram_we    = 1'b1;
          ram_waddr = ram_ix(req_idx, word_cnt);
          ram_wdata = i_mem_rdata;
          if (word_cnt == LAST_WORD) begin
            set_valid  = 1'b1;
            clr_dirty  = 1'b1;
            tag_we     = 1'b1;
            word_cnt_n = '0;
            state_n    = S_IDLE;
            mem_req_n  = 1'b0;
          end else begin
            word_cnt_n = word_nxt;
            mem_addr_n = make_addr(req_tag, req_idx, word_nxt);
          end
        end
      end

      S_FL_SCAN: begin
        if (valid[line_cnt] && dirty[line_cnt]) begin
          state_n     = S_FL_WB;
          word_cnt_n  = '0;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b1;
          mem_addr_n  = make_addr(tag_ram[line_cnt], line_cnt, '0);
          mem_wdata_n = data_ram[ram_ix(line_cnt, '0)];
        end else if (line_cnt == LAST_LINE) begin
          state_n      = S_IDLE;
          flush_done_n = 1'b1;
        end else begin
          line_cnt_n = line_cnt + IW'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Storage arrays carry no reset; valid bits alone decide whether their contents matter.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) data_ram[ram_waddr] <= ram_wdata;
    if (tag_we && !rst) tag_ram[req_idx] <= req_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      word_cnt     <= '0;
      line_cnt     <= '0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_flush_done <= 1'b0;
      miss_pending <= 1'b0;
      data_q       <= '0;
      valid        <= '0;
      dirty        <= '0;
      o_hit_cnt    <= '0;
      o_miss_cnt   <= '0;
    end else begin
      state        <= state_n;
      word_cnt     <= word_cnt_n;
      line_cnt     <= line_cnt_n;
      o_mem_req    <= mem_req_n;
      o_mem_we     <= mem_we_n;
      o_mem_addr   <= mem_addr_n;
      o_mem_wdata  <= mem_wdata_n;
      o_flush_done <= flush_done_n;
      miss_pending <= miss_pending_n;
      if (rd_hit)    data_q <= req_word_data;
      if (set_valid) valid[req_idx] <= 1'b1;
      if (clr_dirty) dirty[line_idx] <= 1'b0;
      if (set_dirty) dirty[req_idx] <= 1'b1;
      if (count_hit && (o_hit_cnt != 32'hFFFF_FFFF))   o_hit_cnt  <= o_hit_cnt + 32'd1;
      if (count_miss && (o_miss_cnt != 32'hFFFF_FFFF)) o_miss_cnt <= o_miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_cache_wb_line_ctrl.sv
// Testbench for cache_wb_line_ctrl: 4 lines x 4 words, req/ack memory slave acking
// two cycles after a request, reference model = flat memory image plus per-line tag state.
module tb_cache_wb_line_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rd_en = 1'b0;
  logic        i_wr_en = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_data = '0;
  logic [3:0]  i_mask = '0;
  logic [31:0] o_data;
  logic        o_busy;
  logic        o_flush_done;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic [31:0] o_hit_cnt;
  logic [31:0] o_miss_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] seed = 32'h0;
  logic [31:0] mem  [logic [31:0]];
  logic [31:0] flat [logic [31:0]];
  logic [64:0] log_q [$];
  logic [64:0] exp_q [$];
  int          ack_cnt = 0;

  bit          mvalid [4];
  bit          mdirty [4];
  logic [25:0] mtag   [4];
  int          m_hit  = 0;
  int          m_miss = 0;

  cache_wb_line_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .LINES      (4),
    .LINE_WORDS (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rd_en      (i_rd_en),
    .i_wr_en      (i_wr_en),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .i_mask       (i_mask),
    .o_data       (o_data),
    .o_busy       (o_busy),
    .i_flush      (i_flush),
    .o_flush_done (o_flush_done),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_hit_cnt    (o_hit_cnt),
    .o_miss_cnt   (o_miss_cnt)
  );

  always #5 clk = ~clk;

  // Power-on memory image; word 0x008 is pinned so the byte-merge case has a known victim.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h1122_3344;
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] flat_rd(input logic [31:0] a);
    if (flat.exists(a)) return flat[a];
    return init_val(a);
  endfunction

  // Memory slave: acks on the second falling edge of a request, logging every transfer.
  always @(negedge clk) begin
    if (!o_mem_req) begin
      ack_cnt   = 0;
      i_mem_ack = 1'b0;
    end else if (i_mem_ack) begin
      ack_cnt   = 0;
      i_mem_ack = 1'b0;
    end else begin
      ack_cnt++;
      if (ack_cnt == 2) begin
        if (o_mem_we) begin
          mem[o_mem_addr] = o_mem_wdata;
          log_q.push_back({1'b1, o_mem_addr, o_mem_wdata});
        end else begin
          i_mem_rdata = mem_rd(o_mem_addr);
          log_q.push_back({1'b0, o_mem_addr, i_mem_rdata});
        end
        i_mem_ack = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] m,
                               output bit first_busy, output logic [31:0] rdata);
    int n;
    @(negedge clk);
    i_rd_en = rd;
    i_wr_en = wr;
    i_addr  = a;
    i_data  = d;
    i_mask  = m;
    #1;
    first_busy = o_busy;
    n = 0;
    while (o_busy && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("req_timeout", 96'(n < 400), 96'(1));
    rdata = o_data;
    @(posedge clk);
    #1;
    i_rd_en = 1'b0;
    i_wr_en = 1'b0;
  endtask

  task automatic checkTraffic(input string tag);
    checkOutput({tag, "_count"}, 96'(log_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      checkOutput(tag, 96'(log_q[i]), 96'(exp_q[i]));
  endtask

  task automatic runOp(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, output logic [31:0] rdata);
    logic [1:0]  idx;
    logic [25:0] tag;
    logic [31:0] wa, va, v;
    bit          exp_hit, first_busy;
    idx = a[5:4];
    tag = a[31:6];
    wa  = {a[31:2], 2'b00};
    exp_hit = mvalid[idx] && (mtag[idx] == tag);
    exp_q.delete();
    if (!exp_hit) begin
      if (mvalid[idx] && mdirty[idx]) begin
        for (int w = 0; w < 4; w++) begin
          va = {mtag[idx], idx, 2'(w), 2'b00};
          exp_q.push_back({1'b1, va, flat_rd(va)});
        end
      end
      for (int w = 0; w < 4; w++) begin
        va = {tag, idx, 2'(w), 2'b00};
        exp_q.push_back({1'b0, va, flat_rd(va)});
      end
      mvalid[idx] = 1'b1;
      mtag[idx]   = tag;
      mdirty[idx] = 1'b0;
      m_miss++;
    end else begin
      m_hit++;
    end
    log_q.delete();
    applyStimulus(rd, wr, a, d, m, first_busy, rdata);
    checkOutput("first_busy", 96'(first_busy), 96'(!exp_hit));
    if (rd) begin
      checkOutput("rdata", 96'(rdata), 96'(flat_rd(wa)));
    end else begin
      v = flat_rd(wa);
      for (int b = 0; b < 4; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
      flat[wa]    = v;
      mdirty[idx] = 1'b1;
    end
    checkTraffic("traffic");
    checkOutput("hit_cnt", 96'(o_hit_cnt), 96'(m_hit));
    checkOutput("miss_cnt", 96'(o_miss_cnt), 96'(m_miss));
  endtask

  task automatic runFlush(input string tag);
    logic [31:0] va;
    int n, pulses;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      if (mvalid[i] && mdirty[i]) begin
        for (int w = 0; w < 4; w++) begin
          va = {mtag[i], 2'(i), 2'(w), 2'b00};
          exp_q.push_back({1'b1, va, flat_rd(va)});
        end
        mdirty[i] = 1'b0;
      end
    end
    log_q.delete();
    pulses = 0;
    @(negedge clk);
    i_flush = 1'b1;
    n = 0;
    while (n < 600) begin
      @(negedge clk);
      #1;
      n++;
      if (o_flush_done) begin
        pulses++;
        i_flush = 1'b0;
        break;
      end
    end
    i_flush = 1'b0;
    checkOutput({tag, "_timeout"}, 96'(n < 600), 96'(1));
    repeat (8) begin
      @(negedge clk);
      #1;
      if (o_flush_done) pulses++;
    end
    checkOutput({tag, "_pulses"}, 96'(pulses), 96'(1));
    checkTraffic(tag);
  endtask

  initial begin
    logic [31:0] rdata, a, d;
    logic [3:0]  m;
    int          kind, n;
    bit          rd, wr;

    seed = $urandom;
    for (int i = 0; i < 4; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = '0;
    end

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_o_data", 96'(o_data), 96'(0));
    checkOutput("rst_o_busy", 96'(o_busy), 96'(0));
    checkOutput("rst_mem_req", 96'(o_mem_req), 96'(0));
    checkOutput("rst_flush_done", 96'(o_flush_done), 96'(0));
    checkOutput("rst_hit_cnt", 96'(o_hit_cnt), 96'(0));
    checkOutput("rst_miss_cnt", 96'(o_miss_cnt), 96'(0));
    rst = 1'b0;

    $display("[TB] cold read and line hits");
    runOp(1'b1, 1'b0, 32'h000, 32'h0, 4'h0, rdata);
    runOp(1'b1, 1'b0, 32'h004, 32'h0, 4'h0, rdata);
    runOp(1'b1, 1'b0, 32'h008, 32'h0, 4'h0, rdata);
    checkOutput("line_word2", 96'(rdata), 96'(32'h1122_3344));
    runOp(1'b1, 1'b0, 32'h00C, 32'h0, 4'h0, rdata);
    checkOutput("cold_hits", 96'(o_hit_cnt), 96'(3));

    $display("[TB] masked write hit");
    runOp(1'b0, 1'b1, 32'h008, 32'hAABB_CCDD, 4'b0101, rdata);
    runOp(1'b1, 1'b0, 32'h008, 32'h0, 4'h0, rdata);
    checkOutput("wr_merge", 96'(rdata), 96'(32'h11BB_33DD));
    runOp(1'b0, 1'b1, 32'h004, 32'hFFFF_FFFF, 4'b0000, rdata);

    $display("[TB] dirty eviction");
    runOp(1'b1, 1'b0, 32'h048, 32'h0, 4'h0, rdata);
    checkOutput("evict_word2", 96'((log_q.size() > 2) ? log_q[2] : 65'h0),
                96'({1'b1, 32'h008, 32'h11BB_33DD}));

    $display("[TB] flush with lines 1 and 3 dirty");
    runOp(1'b0, 1'b1, 32'h010, 32'hCAFE_0010, 4'b1111, rdata);
    runOp(1'b0, 1'b1, 32'h0F4, 32'hBEEF_00F4, 4'b0011, rdata);
    runFlush("flush1");
    runFlush("flush2");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 48; i++) begin
      kind = $urandom_range(0, 9);
      rd   = (kind < 5) || (kind == 9);
      wr   = (kind >= 5);
      a    = $urandom_range(0, 255) & 32'hFFFF_FFFC;
      d    = $urandom;
      m    = 4'($urandom_range(0, 15));
      runOp(rd, wr, a, d, m, rdata);
      if (i % 16 == 15) runFlush("flush_rand");
    end
    runFlush("flush_final");

    $display("[TB] reset during fill");
    log_q.delete();
    @(negedge clk);
    i_rd_en = 1'b1;
    i_addr  = 32'h200;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      #1;
      n++;
      if (log_q.size() >= 2 && !i_mem_ack && o_mem_req) break;
    end
    checkOutput("fill3_timeout", 96'(n < 400), 96'(1));
    rst     = 1'b1;
    i_rd_en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_mem_req", 96'(o_mem_req), 96'(0));
    checkOutput("abort_busy", 96'(o_busy), 96'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    m_hit  = 0;
    m_miss = 0;
    #1;
    checkOutput("abort_hit_cnt", 96'(o_hit_cnt), 96'(m_hit));
    runOp(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, rdata);
    runOp(1'b1, 1'b0, 32'h000, 32'h0, 4'h0, rdata);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
